// File: rtl/cache_cntrl_nway.sv
// cache_cntrl_nway
// N-way set-associative, write-back / write-allocate cache controller.
// It sits between the pipeline memory stage and the external tag/data way
// arrays, and drives a pipelined main memory (one read per cycle, data back
// MEM_LAT cycles later).
//
// Address split: addr = {tag[TAG_W], idx[IDX_W], offset[OFF_W]}, where
// offset = {word, 1'b0}.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   rd, wr             request strobes (sampled only while Stall=0)
//   addr, data_in      byte address and write data
//   DataOut            read data, valid while Done=1
//   Done               one-cycle completion pulse
//   Stall              controller busy, requests ignored
//   CacheHit           request completed as a hit
//   Err                illegal request (rd&wr or odd address), with Done
//   arr_*              drive/observe the external way arrays
//   mem_*              pipelined main memory interface
//   state_dbg          current FSM state (debug observation)
//
// Handshake: a request is accepted on the rising edge where Stall=0 and
// rd|wr=1. From then on Stall stays high until the cycle after Done, and
// rd/wr are ignored. Done is a single-cycle pulse; DataOut/CacheHit/Err are
// meaningful only in that cycle.
//
// Optional build macro CACHE_STATS_EN adds saturating hit_cnt / miss_cnt
// outputs counting COMP hits and misses.

module cache_cntrl_nway #(
  parameter int WAYS    = 2,
  parameter int TAG_W   = 5,
  parameter int IDX_W   = 8,
  parameter int WORDS   = 4,
  parameter int MEM_LAT = 2,
  localparam int OFF_W  = $clog2(WORDS) + 1,
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [15:0]           addr,
  input  logic [15:0]           data_in,
  output logic [15:0]           DataOut,
  output logic                  Done,
  output logic                  Stall,
  output logic                  CacheHit,
  output logic                  Err,
  output logic [WAYS-1:0]       arr_en,
  output logic [IDX_W-1:0]      arr_idx,
  output logic [OFF_W-1:0]      arr_offset,
  output logic                  arr_comp,
  output logic                  arr_write,
  output logic [TAG_W-1:0]      arr_tag_in,
  output logic [15:0]           arr_data_in,
  output logic                  arr_valid_in,
  input  logic [WAYS-1:0]       arr_hit,
  input  logic [WAYS-1:0]       arr_valid,
  input  logic [WAYS-1:0]       arr_dirty,
  input  logic [WAYS*TAG_W-1:0] arr_tag_out,
  input  logic [WAYS*16-1:0]    arr_data_out,
  output logic [15:0]           mem_addr,
  output logic [15:0]           mem_data_in,
  output logic                  mem_wr,
  output logic                  mem_rd,
  input  logic [15:0]           mem_data_out,
  output logic [2:0]            state_dbg
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt
`endif
);

  localparam int WORD_W = $clog2(WORDS);
  localparam int CW     = $clog2(WORDS + MEM_LAT + 1);

  typedef enum logic [2:0] {IDLE, COMP, EVICT, FILL, FIN} state_t;

  state_t             state;
  logic               op_wr;
  logic               err_q;
  logic [TAG_W-1:0]   tag_q;
  logic [IDX_W-1:0]   idx_q;
  logic [OFF_W-1:0]   off_q;
  logic [15:0]        data_q;
  logic [WAY_W-1:0]   victim;
  logic [TAG_W-1:0]   victim_tag;
  logic [WAY_W-1:0]   rr_ptr;
  logic [CW-1:0]      cnt;
  logic [15:0]        data_reg;

  logic               hit_any;
  logic [15:0]        hit_data;
  logic [WAY_W-1:0]   vsel;
  logic [WAYS-1:0]    victim_oh;
  logic [15:0]        victim_data;
  logic [WORD_W-1:0]  evict_word;
  logic [WORD_W-1:0]  fill_word;
  logic               req_bad;

  assign hit_any     = |arr_hit;
  assign victim_oh   = WAYS'(1) << victim;
  assign victim_data = arr_data_out[int'(victim)*16 +: 16];
  assign evict_word  = cnt[WORD_W-1:0];
  // Word landing in the array this FILL cycle (memory answers MEM_LAT late).
  assign fill_word   = WORD_W'(cnt - CW'(MEM_LAT));
  assign req_bad     = (rd & wr) | addr[0];
  assign state_dbg   = state;

  // Hit data and victim choice. Descending loop so the lowest index wins;
  // with no invalid way the round-robin pointer stays as the victim.
  always_comb begin
    hit_data = '0;
    vsel     = rr_ptr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (arr_hit[w])    hit_data = arr_data_out[w*16 +: 16];
      if (!arr_valid[w]) vsel     = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_wr      <= 1'b0;
      err_q      <= 1'b0;
      tag_q      <= '0;
      idx_q      <= '0;
      off_q      <= '0;
      data_q     <= '0;
      victim     <= '0;
      victim_tag <= '0;
      rr_ptr     <= '0;
      cnt        <= '0;
      data_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd | wr) begin
            tag_q  <= addr[15 -: TAG_W];
            idx_q  <= addr[OFF_W +: IDX_W];
            off_q  <= addr[OFF_W-1:0];
            data_q <= data_in;
            op_wr  <= wr & ~rd;
            err_q  <= req_bad;
            cnt    <= '0;
            state  <= req_bad ? FIN : COMP;
          end
        end
        COMP: begin
          cnt <= '0;
          if (hit_any) begin
            data_reg <= hit_data;
            state    <= IDLE;
          end else begin
            victim     <= vsel;
            victim_tag <= arr_tag_out[int'(vsel)*TAG_W +: TAG_W];
            if (&arr_valid) rr_ptr <= rr_ptr + WAY_W'(1);
            state <= (arr_valid[vsel] & arr_dirty[vsel]) ? EVICT : FILL;
          end
        end
        EVICT: begin
          if (cnt == CW'(WORDS - 1)) begin
            cnt   <= '0;
            state <= FILL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FILL: begin
          if (cnt >= CW'(MEM_LAT) && !op_wr && fill_word == off_q[OFF_W-1:1])
            data_reg <= mem_data_out;
          if (cnt == CW'(WORDS + MEM_LAT - 1)) begin
            cnt   <= '0;
            state <= FIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIN: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array and memory strobes decode straight from the registered state so
  // the external arrays answer within the same cycle.
  always_comb begin
    arr_en       = '0;
    arr_idx      = idx_q;
    arr_offset   = off_q;
    arr_comp     = 1'b0;
    arr_write    = 1'b0;
    arr_tag_in   = tag_q;
    arr_data_in  = data_q;
    arr_valid_in = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_wr       = 1'b0;
    mem_rd       = 1'b0;
    Done         = 1'b0;
    CacheHit     = 1'b0;
    Err          = 1'b0;
    Stall        = (state != IDLE);
    DataOut      = data_reg;
    case (state)
      COMP: begin
        arr_en       = '1;
        arr_comp     = 1'b1;
        arr_write    = op_wr;
        arr_valid_in = 1'b1;
        Done         = hit_any;
        CacheHit     = hit_any;
        DataOut      = hit_data;
      end
      EVICT: begin
        arr_en      = victim_oh;
        arr_offset  = {evict_word, 1'b0};
        mem_wr      = 1'b1;
        mem_addr    = {victim_tag, idx_q, evict_word, 1'b0};
        mem_data_in = victim_data;
      end
      FILL: begin
        if (cnt < CW'(WORDS)) begin
          mem_rd   = 1'b1;
          mem_addr = {tag_q, idx_q, cnt[WORD_W-1:0], 1'b0};
        end
        if (cnt >= CW'(MEM_LAT)) begin
          arr_en       = victim_oh;
          arr_offset   = {fill_word, 1'b0};
          arr_write    = 1'b1;
          arr_valid_in = 1'b1;
          arr_data_in  = mem_data_out;
        end
      end
      FIN: begin
        Done = 1'b1;
        Err  = err_q;
        // A write miss merges its data once the line is resident; this
        // compare-write also marks the line dirty.
        if (!err_q && op_wr) begin
          arr_en       = victim_oh;
          arr_comp     = 1'b1;
          arr_write    = 1'b1;
          arr_valid_in = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == COMP) begin
      if (hit_any) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cache_cntrl_nway.md
Name: cache_cntrl_nway

Overview:
Parametrised N-way set-associative, write-back/write-allocate cache controller for the WISC memory system. It sits between the pipeline's memory stage and the external tag/data way arrays, and drives a pipelined main memory. It generalises the 2-way controller with these additions:
- configurable way count, line size and memory latency
- request latching
- first-invalid/round-robin victim selection
- misaligned/illegal request detection

Parameters:
WAYS, 2, number of ways (power of two, 2..8)
TAG_W, 5, tag bits
IDX_W, 8, index bits
WORDS, 4, 16-bit words per line (power of two); OFF_W = clog2(WORDS)+1; TAG_W+IDX_W+OFF_W must equal 16
MEM_LAT, 2, cycles from mem_rd issue to mem_data_out valid (memory is pipelined, one request per cycle)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rd  in  1  read request
wr  in  1  write request
addr  in  16  byte address
data_in  in  16  write data
DataOut  out  16  read data, valid while Done=1
Done  out  1  request complete (one-cycle pulse)
Stall  out  1  controller busy; requests ignored
CacheHit  out  1  request completed as a hit
Err  out  1  illegal request (one-cycle pulse, with Done)
arr_en  out  WAYS  one-hot or all-ones way enable
arr_idx  out  IDX_W  array index
arr_offset  out  OFF_W  array byte offset
arr_comp  out  1  compare mode
arr_write  out  1  array write
arr_tag_in  out  TAG_W  tag to arrays
arr_data_in  out  16  data to arrays
arr_valid_in  out  1  valid bit to arrays
arr_hit  in  WAYS  per-way hit
arr_valid  in  WAYS  per-way valid
arr_dirty  in  WAYS  per-way dirty
arr_tag_out  in  WAYS*TAG_W  per-way tag, way0 in LSBs
arr_data_out  in  WAYS*16  per-way data, way0 in LSBs
mem_addr  out  16  memory address
mem_data_in  out  16  memory write data
mem_wr  out  1  memory write strobe
mem_rd  out  1  memory read strobe
mem_data_out  in  16  memory read data

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, rr_ptr=0, counters cleared.
  - Outputs go to 0: Done, CacheHit, Err, mem_wr, mem_rd, arr_en, arr_write, DataOut.
  - Stall=0.
  - Reads in flight at reset are discarded.
- States: IDLE, COMP, EVICT, FILL, FIN.
- IDLE: Stall=0. On rd^wr, latch addr, data_in and op, then go to COMP.
  - rd&wr, or addr[0]=1: pulse Done=1 and Err=1 next cycle (1-cycle ERR path through FIN); no array or memory activity.
- Any state other than IDLE: Stall=1; rd/wr ignored.
- COMP (cycle 1 after accept):
  - Drive arr_en=all ones, arr_comp=1, arr_write=op_wr, with latched idx/offset/tag/data.
  - Any arr_hit: Done=1 and CacheHit=1 this cycle; DataOut=data of the hit way; return to IDLE.
  - Miss: select victim = lowest-index way with arr_valid=0; if all ways are valid, victim = rr_ptr and rr_ptr increments mod WAYS.
  - Latch victim and its tag. Next state is EVICT if the victim is valid&dirty, otherwise FILL.
- EVICT (WORDS cycles, k=0..WORDS-1):
  - Array side: arr_en=victim one-hot, arr_comp=0, arr_write=0, arr_offset={k,0}.
  - Memory side: mem_wr=1, mem_addr={victim tag, idx, k, 0}, mem_data_in=victim way's arr_data_out.
- FILL (WORDS+MEM_LAT cycles, c=0..):
  - Cycles c<WORDS: mem_rd=1, mem_addr={tag, idx, c, 0}.
  - Cycles c>=MEM_LAT: word j=c-MEM_LAT is written to the victim: arr_comp=0, arr_write=1, arr_valid_in=1, arr_tag_in=tag, arr_data_in=mem_data_out.
  - If j is the requested word and op=rd, capture mem_data_out into DataOut.
- FIN (1 cycle): Done=1, CacheHit=0, return to IDLE.
  - If op=wr: arr_en=victim, arr_comp=1, arr_write=1, arr_data_in=latched data_in. This sets dirty and overwrites the requested word.
- Miss latency from the accept edge (defaults): clean miss Done in cycle WORDS+MEM_LAT+2 = 8; dirty miss Done in cycle 2*WORDS+MEM_LAT+2 = 12.
- No overlap: mem_wr and mem_rd are never both 1 in the same cycle.

Optional Feature:
CACHE_STATS_EN: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
- Each counter saturates at 16'hFFFF.
- hit_cnt increments on a COMP hit; miss_cnt increments on a COMP miss. Err requests count in neither.
- Both counters clear on rst.
- Without the macro, the ports and counters do not exist.

Test Plan:
- Cold read addr=16'h0804, memory preloaded with the line → 8-cycle latency, one mem_rd per cycle for 4 cycles, DataOut=mem[0x0804], CacheHit=0.
- Repeat the same read → Done and CacheHit in cycle 1, no memory strobes.
- Write 16'hBEEF to 0x0804, then read 0x2004 and 0x4004 (same index, WAYS=2):
  - 0x2004 fills the invalid way1.
  - 0x4004 evicts way0 (rr_ptr=0) with 4 mem_wr to 0x0800..0x0806; mem at 0x0804 = 16'hBEEF.
- Read 0x0804 after that eviction → miss; victim=way1 (rr_ptr=1); 12-cycle latency if way1 is dirty, else 8; DataOut=16'hBEEF.
- rd=wr=1, or addr=16'h0003 → Done=1 and Err=1 one cycle later; no arr/mem activity; the next legal request is accepted normally.
- Assert rst during FILL → all outputs 0 immediately, Stall=0; the next read of the same address misses and refills cleanly.
